// File: rtl/sata_link_pkg.sv
// Shared link-layer constants and state encoding for the TX path.
package sata_link_pkg;

  localparam logic [31:0] ALIGN_PRIM   = 32'h7B4A4ABC;
  localparam logic        ALIGN_PRIM_K = 1'b1;

  typedef enum logic [1:0] {
    LINKDOWN,
    PASS,
    BURST
  } link_state_t;

endpackage

// File: rtl/sata_align_scheduler.sv
// TX ALIGN scheduler: preempts the link-layer DWORD stream for ALIGN bursts.
// Optional burst statistics counter: define SATA_ALIGN_STATS_EN.
import sata_link_pkg::*;

module sata_align_scheduler #(
  parameter int ALIGN_INTERVAL = 254,
  parameter int ALIGN_BURST    = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        LINKUP,
  input  logic        FORCE_ALIGN,
  input  logic [31:0] TX_DATA_IN,
  input  logic        TX_CHARISK_IN,
  output logic        TX_ACCEPT,
  output logic [31:0] TX_DATA_OUT,
  output logic        TX_CHARISK_OUT,
  output logic        ALIGN_ACTIVE,
  output logic [15:0] ALIGN_BURST_CNT
);

  localparam logic [7:0] IVL   = 8'(ALIGN_INTERVAL);
  localparam logic [1:0] BLAST = 2'(ALIGN_BURST - 1);

  link_state_t state, state_d;
  logic [7:0]  icnt, icnt_d, icnt_inc;
  logic [1:0]  bcnt, bcnt_d;
  logic        pend, pend_d;

  assign TX_ACCEPT = (state == PASS) && LINKUP;
  assign icnt_inc  = icnt + 8'd1;

  // Interval expiry and a pending force share one transition: one burst only
  always_comb begin
    state_d = state;
    icnt_d  = icnt;
    bcnt_d  = bcnt;
    pend_d  = pend | FORCE_ALIGN;
    unique case (state)
      LINKDOWN: begin
        icnt_d = '0;
        bcnt_d = '0;
        pend_d = 1'b0;
        if (LINKUP) state_d = PASS;
      end
      PASS: begin
        if (!LINKUP) begin
          state_d = LINKDOWN;
        end else if (icnt_inc == IVL || pend_d) begin
          state_d = BURST;
          icnt_d  = '0;
          bcnt_d  = '0;
          pend_d  = 1'b0;
        end else begin
          icnt_d = icnt_inc;
        end
      end
      BURST: begin
        pend_d = 1'b0;
        if (!LINKUP) begin
          state_d = LINKDOWN;
        end else if (bcnt == BLAST) begin
          state_d = PASS;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt + 2'd1;
        end
      end
      default: state_d = LINKDOWN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= LINKDOWN;
      icnt           <= '0;
      bcnt           <= '0;
      pend           <= 1'b0;
      TX_DATA_OUT    <= ALIGN_PRIM;
      TX_CHARISK_OUT <= ALIGN_PRIM_K;
      ALIGN_ACTIVE   <= 1'b1;
    end else begin
      state <= state_d;
      icnt  <= icnt_d;
      bcnt  <= bcnt_d;
      pend  <= pend_d;
      if (TX_ACCEPT) begin
        TX_DATA_OUT    <= TX_DATA_IN;
        TX_CHARISK_OUT <= TX_CHARISK_IN;
        ALIGN_ACTIVE   <= 1'b0;
      end else begin
        TX_DATA_OUT    <= ALIGN_PRIM;
        TX_CHARISK_OUT <= ALIGN_PRIM_K;
        ALIGN_ACTIVE   <= 1'b1;
      end
    end
  end

`ifdef SATA_ALIGN_STATS_EN
  logic [15:0] bursts;
  logic        burst_go;

  assign burst_go = (state == PASS) && (state_d == BURST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      bursts <= '0;
    else if (burst_go && bursts != 16'hFFFF)
      bursts <= bursts + 16'd1;
  end

  assign ALIGN_BURST_CNT = bursts;
`else
  assign ALIGN_BURST_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_sata_align_scheduler.sv
// Scoreboard bench for sata_align_scheduler (default and 2/4 configurations).
module tb_sata_align_scheduler;

  localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
`ifdef SATA_ALIGN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK;
  logic        RESET_N;
  logic        LINKUP, FORCE_ALIGN, TX_CHARISK_IN;
  logic [31:0] TX_DATA_IN;
  logic        TX_ACCEPT, TX_CHARISK_OUT, ALIGN_ACTIVE;
  logic [31:0] TX_DATA_OUT;
  logic [15:0] ALIGN_BURST_CNT;

  logic        LINKUP_2, FORCE_2, TX_CHARISK_IN_2;
  logic [31:0] TX_DATA_IN_2;
  logic        TX_ACCEPT_2, TX_CHARISK_OUT_2, ALIGN_ACTIVE_2;
  logic [31:0] TX_DATA_OUT_2;
  logic [15:0] ALIGN_BURST_CNT_2;

  sata_align_scheduler dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .LINKUP         (LINKUP),
    .FORCE_ALIGN    (FORCE_ALIGN),
    .TX_DATA_IN     (TX_DATA_IN),
    .TX_CHARISK_IN  (TX_CHARISK_IN),
    .TX_ACCEPT      (TX_ACCEPT),
    .TX_DATA_OUT    (TX_DATA_OUT),
    .TX_CHARISK_OUT (TX_CHARISK_OUT),
    .ALIGN_ACTIVE   (ALIGN_ACTIVE),
    .ALIGN_BURST_CNT(ALIGN_BURST_CNT)
  );

  sata_align_scheduler #(.ALIGN_INTERVAL(2), .ALIGN_BURST(4)) dut2 (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .LINKUP         (LINKUP_2),
    .FORCE_ALIGN    (FORCE_2),
    .TX_DATA_IN     (TX_DATA_IN_2),
    .TX_CHARISK_IN  (TX_CHARISK_IN_2),
    .TX_ACCEPT      (TX_ACCEPT_2),
    .TX_DATA_OUT    (TX_DATA_OUT_2),
    .TX_CHARISK_OUT (TX_CHARISK_OUT_2),
    .ALIGN_ACTIVE   (ALIGN_ACTIVE_2),
    .ALIGN_BURST_CNT(ALIGN_BURST_CNT_2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // {active, charisk, data}
  logic [33:0] q[$];
  logic [33:0] q2[$];

  int m_st = 0;
  int m_cnt = 0;
  int m_b = 0;
  int m_bursts = 0;
  int din = 0;

  int p2 = 0;
  bit started2 = 1'b0;
  int bursts2 = 0;
  int din2 = 0;

  function automatic logic [31:0] dval(input int d);
    return (d == 300) ? ALIGN_W : 32'(d);
  endfunction

  function automatic logic kval(input int d);
    return (d == 300) || (d % 16 == 5);
  endfunction

  task automatic tick();
    logic ea, adv;
    logic [33:0] e;
    ea = (m_st == 1) && LINKUP;
    #1;
    chk("accept", 32'(TX_ACCEPT), 32'(ea));
    if (ea) q.push_back({1'b0, TX_CHARISK_IN, TX_DATA_IN});
    else    q.push_back({1'b1, 1'b1, ALIGN_W});
    adv = TX_ACCEPT;
    @(posedge CLK);
    case (m_st)
      0: if (LINKUP) begin m_st = 1; m_cnt = 0; end
      1: if (!LINKUP) m_st = 0;
         else begin
           m_cnt++;
           if (m_cnt == 254 || FORCE_ALIGN) begin
             m_st = 2; m_cnt = 0; m_b = 0; m_bursts++;
           end
         end
      default: if (!LINKUP) m_st = 0;
         else begin m_b++; if (m_b == 2) m_st = 1; end
    endcase
    @(negedge CLK);
    e = q.pop_front();
    chk("data", TX_DATA_OUT, e[31:0]);
    chk("charisk", 32'(TX_CHARISK_OUT), 32'(e[32]));
    chk("active", 32'(ALIGN_ACTIVE), 32'(e[33]));
    chk("bcnt", 32'(ALIGN_BURST_CNT), STATS ? 32'(m_bursts) : 32'd0);
    FORCE_ALIGN = 1'b0;
    if (adv) begin
      din++;
      TX_DATA_IN = dval(din);
      TX_CHARISK_IN = kval(din);
    end
  endtask

  task automatic tick2();
    logic ea, adv;
    logic [33:0] e;
    ea = started2 && (p2 < 2);
    #1;
    chk("accept2", 32'(TX_ACCEPT_2), 32'(ea));
    if (ea) q2.push_back({1'b0, TX_CHARISK_IN_2, TX_DATA_IN_2});
    else    q2.push_back({1'b1, 1'b1, ALIGN_W});
    adv = TX_ACCEPT_2;
    @(posedge CLK);
    if (!started2) started2 = 1'b1;
    else begin
      if (p2 == 1) bursts2++;
      p2 = (p2 + 1) % 6;
    end
    @(negedge CLK);
    e = q2.pop_front();
    chk("data2", TX_DATA_OUT_2, e[31:0]);
    chk("charisk2", 32'(TX_CHARISK_OUT_2), 32'(e[32]));
    chk("active2", 32'(ALIGN_ACTIVE_2), 32'(e[33]));
    if (adv) begin
      din2++;
      TX_DATA_IN_2 = 32'(din2);
      TX_CHARISK_IN_2 = din2[0];
    end
  endtask

  initial begin
    int n;
    int b0;
    RESET_N = 1'b0;
    LINKUP = 1'b0;
    FORCE_ALIGN = 1'b0;
    TX_DATA_IN = dval(0);
    TX_CHARISK_IN = kval(0);
    LINKUP_2 = 1'b0;
    FORCE_2 = 1'b0;
    TX_DATA_IN_2 = 32'd0;
    TX_CHARISK_IN_2 = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_data", TX_DATA_OUT, ALIGN_W);
    chk("rst_k", 32'(TX_CHARISK_OUT), 32'd1);
    chk("rst_active", 32'(ALIGN_ACTIVE), 32'd1);
    chk("rst_accept", 32'(TX_ACCEPT), 32'd0);
    chk("rst_bcnt", 32'(ALIGN_BURST_CNT), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    tick();
    chk("idle_accept", 32'(TX_ACCEPT), 32'd0);

    // Steady state over four periods
    LINKUP = 1'b1;
    repeat (4 * 256 + 2) tick();

    // Force on the 10th accept of a period
    n = 0;
    while (!(m_st == 1 && m_cnt == 9) && n < 600) begin tick(); n++; end
    chk("reach_force10", 32'(n < 600), 32'd1);
    FORCE_ALIGN = 1'b1;
    tick();
    chk("force10_stall", 32'(TX_ACCEPT), 32'd0);
    repeat (300) tick();

    // Force coinciding with interval expiry
    n = 0;
    while (!(m_st == 1 && m_cnt == 253) && n < 600) begin tick(); n++; end
    chk("reach_force254", 32'(n < 600), 32'd1);
    b0 = m_bursts;
    FORCE_ALIGN = 1'b1;
    tick();
    chk("force254_cnt", 32'(ALIGN_BURST_CNT), STATS ? 32'(b0 + 1) : 32'd0);
    repeat (2) tick();
    chk("force254_resume", 32'(TX_ACCEPT), 32'd1);
    repeat (20) tick();

    // Link drop during the first burst cycle
    n = 0;
    while (!(m_st == 2 && m_b == 0) && n < 600) begin tick(); n++; end
    chk("reach_burst", 32'(n < 600), 32'd1);
    LINKUP = 1'b0;
    FORCE_ALIGN = 1'b1;
    repeat (6) tick();
    LINKUP = 1'b1;
    repeat (300) tick();

    // Short interval, long burst configuration
    LINKUP = 1'b0;
    tick();
    LINKUP_2 = 1'b1;
    repeat (601) tick2();
    chk("bcnt2", 32'(ALIGN_BURST_CNT_2), STATS ? 32'(bursts2) : 32'd0);

    // Asynchronous reset in the middle of a burst
    n = 0;
    while (p2 != 3 && n < 20) begin tick2(); n++; end
    chk("reach_burst2", 32'(n < 20), 32'd1);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("arst_data2", TX_DATA_OUT_2, ALIGN_W);
    chk("arst_k2", 32'(TX_CHARISK_OUT_2), 32'd1);
    chk("arst_active2", 32'(ALIGN_ACTIVE_2), 32'd1);
    chk("arst_accept2", 32'(TX_ACCEPT_2), 32'd0);
    chk("arst_bcnt2", 32'(ALIGN_BURST_CNT_2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
